// File: rtl/nrisc_seq_pkg.sv
// Shared definitions for the nRisc next-PC sequencer.
//   SEQ_*      : seq_op encodings (110/111 are decoded as NEXT)
//   seqStateE  : RUN/HALTED run state
//   ADDR_W_DEF : default address width, matches the PC register
package nrisc_seq_pkg;

    localparam int ADDR_W_DEF = 8;

    localparam logic [2:0] SEQ_NEXT   = 3'b000;
    localparam logic [2:0] SEQ_BRANCH = 3'b001;
    localparam logic [2:0] SEQ_JUMP   = 3'b010;
    localparam logic [2:0] SEQ_CALL   = 3'b011;
    localparam logic [2:0] SEQ_RET    = 3'b100;
    localparam logic [2:0] SEQ_HALT   = 3'b101;

    typedef enum logic {
        S_RUN     = 1'b0,
        S_HALTED  = 1'b1
    } seqStateE;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO.
//   clock : state updates on the falling edge (same edge as the PC register)
//   reset : synchronous active-high, empties the stack (entries are don't-care)
//   push  : write din at entry[depth], depth+1 (ignored when full)
//   pop   : depth-1 (ignored when empty)
//   top   : entry[depth-1], valid when !empty
//   depth : occupancy, 0..DEPTH
//   full / empty : occupancy flags
module ret_stack #(
    parameter  int DEPTH = 4,
    parameter  int W     = 8,
    localparam int DW    = $clog2(DEPTH) + 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic [DW-1:0] depth,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  entries [DEPTH];
    logic [DW-1:0] count;
    logic [PW-1:0] wrIdx;
    logic [PW-1:0] rdIdx;

    // Index wraps harmlessly: wrIdx is only used when not full, rdIdx only when not empty.
    assign wrIdx = count[PW-1:0];
    assign rdIdx = wrIdx - PW'(1);

    assign full  = (count == DW'(DEPTH));
    assign empty = (count == '0);
    assign top   = entries[rdIdx];
    assign depth = count;

    always_ff @(negedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (push && !full) begin
            entries[wrIdx] <= din;
            count          <= count + DW'(1);
        end else if (pop && !empty) begin
            count <= count - DW'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC generator for the nRisc monocycle core (write side of the PC register).
//   clock, reset : falling-edge state, synchronous active-high reset
//   PC_atual     : current PC from the PC register
//   seq_op       : NEXT/BRANCH/JUMP/CALL/RET/HALT
//   cond, offset : branch condition and signed displacement
//   target       : absolute JUMP/CALL destination
//   resume       : leave HALTED
//   proxPC, SinalEscPC : next PC and its write enable (combinational)
//   halted, stack_ovf, stack_unf, depth : status
// The PC register ignores reset, so the reset vector is forced through proxPC here.
module pc_sequencer
    import nrisc_seq_pkg::*;
#(
    parameter int              ADDR_W      = ADDR_W_DEF,
    parameter int              STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          PC_atual,
    input  logic [2:0]                 seq_op,
    input  logic                       cond,
    input  logic [ADDR_W-1:0]          offset,
    input  logic [ADDR_W-1:0]          target,
    input  logic                       resume,
    output logic [ADDR_W-1:0]          proxPC,
    output logic                       SinalEscPC,
    output logic                       halted,
    output logic                       stack_ovf,
    output logic                       stack_unf,
    output logic [$clog2(STACK_DEPTH):0] depth
);
    seqStateE          state, stateNext;
    logic [ADDR_W-1:0] pcInc;
    logic [ADDR_W-1:0] stackTop;
    logic              doPush, doPop, setOvf, setUnf;
    logic              stackFull, stackEmpty;

    // Same-width add gives both the wrap and the sign extension of offset for free.
    assign pcInc = PC_atual + ADDR_W'(1);

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) uStack (
        .clock (clock),
        .reset (reset),
        .push  (doPush),
        .pop   (doPop),
        .din   (pcInc),
        .top   (stackTop),
        .depth (depth),
        .full  (stackFull),
        .empty (stackEmpty)
    );

    always_ff @(negedge clock) begin
        if (reset) state <= S_RUN;
        else       state <= stateNext;
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else begin
            if (setOvf) stack_ovf <= 1'b1;
            if (setUnf) stack_unf <= 1'b1;
        end
    end

    assign halted = (state == S_HALTED);

    always_comb begin
        proxPC     = pcInc;
        SinalEscPC = 1'b1;
        doPush     = 1'b0;
        doPop      = 1'b0;
        setOvf     = 1'b0;
        setUnf     = 1'b0;
        stateNext  = state;
        if (reset) begin
            proxPC = RESET_VEC;
        end else if (state == S_HALTED) begin
            proxPC     = PC_atual;
            SinalEscPC = 1'b0;
            if (resume) stateNext = S_RUN;
        end else begin
            case (seq_op)
                SEQ_BRANCH: if (cond) proxPC = pcInc + offset;
                SEQ_JUMP:   proxPC = target;
                SEQ_CALL: begin
                    if (!stackFull) begin
                        proxPC = target;
                        doPush = 1'b1;
                    end else begin
                        proxPC     = PC_atual;
                        SinalEscPC = 1'b0;
                        setOvf     = 1'b1;
                        stateNext  = S_HALTED;
                    end
                end
                SEQ_RET: begin
                    if (!stackEmpty) begin
                        proxPC = stackTop;
                        doPop  = 1'b1;
                    end else begin
                        proxPC     = PC_atual;
                        SinalEscPC = 1'b0;
                        setUnf     = 1'b1;
                        stateNext  = S_HALTED;
                    end
                end
                SEQ_HALT: begin
                    proxPC     = PC_atual;
                    SinalEscPC = 1'b0;
                    stateNext  = S_HALTED;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    logic       clock = 1'b1;
    logic       reset = 1'b0;
    logic [7:0] PC_atual;
    logic [2:0] seq_op = 3'b000;
    logic       cond = 1'b0;
    logic [7:0] offset = 8'h00;
    logic [7:0] target = 8'h00;
    logic       resume = 1'b0;
    logic [7:0] proxPC;
    logic       SinalEscPC;
    logic       halted, stack_ovf, stack_unf;
    logic [2:0] depth;

    // PC register of the core: falling-edge load, no reset; the bench can override it.
    logic [7:0] pcReg = 8'h00;
    logic       pcOvr = 1'b0;
    logic [7:0] pcOvrVal = 8'h00;
    assign PC_atual = pcOvr ? pcOvrVal : pcReg;
    always @(negedge clock) if (SinalEscPC) pcReg <= proxPC;

    always #5 clock = ~clock;

    pc_sequencer #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_VEC(8'h00)) dut (
        .clock(clock), .reset(reset), .PC_atual(PC_atual), .seq_op(seq_op),
        .cond(cond), .offset(offset), .target(target), .resume(resume),
        .proxPC(proxPC), .SinalEscPC(SinalEscPC), .halted(halted),
        .stack_ovf(stack_ovf), .stack_unf(stack_unf), .depth(depth)
    );

    typedef struct {
        int       step;
        bit       chkProx;
        bit [7:0] prox;
        bit       wen;
        bit       hlt;
        bit [2:0] dep;
        bit       ovf;
        bit       unf;
        bit [7:0] pcAfter;
    } expT;

    expT sb[$];
    int  nCmp = 0;
    int  nBad = 0;
    bit  stimDone = 1'b0;

    task automatic chk(input string name, input int step, input int act, input int exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL step %0d %s: got 0x%0h expected 0x%0h", step, name, act, exp);
        end
    endtask

    // Monitor: combinational outputs mid-cycle, committed state just after the falling edge.
    initial begin
        expT e;
        forever begin
            @(posedge clock);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.chkProx) chk("proxPC", e.step, int'(proxPC), int'(e.prox));
                chk("SinalEscPC", e.step, int'(SinalEscPC), int'(e.wen));
                @(negedge clock);
                #1;
                chk("halted", e.step, int'(halted), int'(e.hlt));
                chk("depth", e.step, int'(depth), int'(e.dep));
                chk("stack_ovf", e.step, int'(stack_ovf), int'(e.ovf));
                chk("stack_unf", e.step, int'(stack_unf), int'(e.unf));
                chk("PC", e.step, int'(pcReg), int'(e.pcAfter));
            end
        end
    end

    int stepNo = 0;

    // op, cond, offset, target, resume, reset, pc override (-1 = none), expectations
    task automatic step(input logic [2:0] op, input logic c, input logic [7:0] off,
                        input logic [7:0] tgt, input logic res, input logic rst,
                        input int pcSet, input bit cp, input bit [7:0] prox, input bit wen,
                        input bit hlt, input bit [2:0] dep, input bit ovf, input bit unf,
                        input bit [7:0] pcAfter);
        expT e;
        @(posedge clock);
        seq_op = op; cond = c; offset = off; target = tgt; resume = res; reset = rst;
        pcOvr = (pcSet >= 0);
        pcOvrVal = 8'(pcSet);
        stepNo++;
        e.step = stepNo; e.chkProx = cp; e.prox = prox; e.wen = wen; e.hlt = hlt;
        e.dep = dep; e.ovf = ovf; e.unf = unf; e.pcAfter = pcAfter;
        sb.push_back(e);
    endtask

    initial begin
        // reset and sequential flow
        step(3'd0, 0, 8'h00, 8'h00, 0, 1, -1, 1, 8'h00, 1, 0, 0, 0, 0, 8'h00);
        step(3'd0, 0, 8'h00, 8'h00, 0, 0, -1, 1, 8'h01, 1, 0, 0, 0, 0, 8'h01);
        step(3'd0, 0, 8'h00, 8'h00, 0, 0, -1, 1, 8'h02, 1, 0, 0, 0, 0, 8'h02);
        step(3'd0, 0, 8'h00, 8'h00, 0, 0, -1, 1, 8'h03, 1, 0, 0, 0, 0, 8'h03);
        step(3'd0, 0, 8'h00, 8'h00, 0, 0, -1, 1, 8'h04, 1, 0, 0, 0, 0, 8'h04);
        step(3'd6, 0, 8'h00, 8'h00, 0, 0, 8'hFF, 1, 8'h00, 1, 0, 0, 0, 0, 8'h00);
        // branches
        step(3'd1, 1, 8'hFC, 8'h00, 0, 0, 8'h10, 1, 8'h0D, 1, 0, 0, 0, 0, 8'h0D);
        step(3'd1, 0, 8'hFC, 8'h00, 0, 0, 8'h10, 1, 8'h11, 1, 0, 0, 0, 0, 8'h11);
        step(3'd1, 1, 8'h05, 8'h00, 0, 0, 8'hFE, 1, 8'h04, 1, 0, 0, 0, 0, 8'h04);
        // jump, nested call/ret
        step(3'd2, 0, 8'h00, 8'h05, 0, 0, -1, 1, 8'h05, 1, 0, 0, 0, 0, 8'h05);
        step(3'd3, 0, 8'h00, 8'h40, 0, 0, -1, 1, 8'h40, 1, 0, 1, 0, 0, 8'h40);
        step(3'd3, 0, 8'h00, 8'h60, 0, 0, 8'h41, 1, 8'h60, 1, 0, 2, 0, 0, 8'h60);
        step(3'd4, 0, 8'h00, 8'h00, 0, 0, -1, 1, 8'h42, 1, 0, 1, 0, 0, 8'h42);
        step(3'd4, 0, 8'h00, 8'h00, 0, 0, -1, 1, 8'h06, 1, 0, 0, 0, 0, 8'h06);
        // overflow: stack holds 07, 81, 82, 83
        step(3'd3, 0, 8'h00, 8'h80, 0, 0, -1, 1, 8'h80, 1, 0, 1, 0, 0, 8'h80);
        step(3'd3, 0, 8'h00, 8'h81, 0, 0, -1, 1, 8'h81, 1, 0, 2, 0, 0, 8'h81);
        step(3'd3, 0, 8'h00, 8'h82, 0, 0, -1, 1, 8'h82, 1, 0, 3, 0, 0, 8'h82);
        step(3'd3, 0, 8'h00, 8'h83, 0, 0, -1, 1, 8'h83, 1, 0, 4, 0, 0, 8'h83);
        step(3'd3, 0, 8'h00, 8'h90, 0, 0, -1, 0, 8'h00, 0, 1, 4, 1, 0, 8'h83);
        step(3'd2, 0, 8'h00, 8'h20, 0, 0, -1, 1, 8'h83, 0, 1, 4, 1, 0, 8'h83);
        step(3'd0, 0, 8'h00, 8'h00, 1, 0, -1, 1, 8'h83, 0, 0, 4, 1, 0, 8'h83);
        step(3'd0, 0, 8'h00, 8'h00, 0, 0, -1, 1, 8'h84, 1, 0, 4, 1, 0, 8'h84);
        // drain, then underflow
        step(3'd4, 0, 8'h00, 8'h00, 0, 0, -1, 1, 8'h83, 1, 0, 3, 1, 0, 8'h83);
        step(3'd4, 0, 8'h00, 8'h00, 0, 0, -1, 1, 8'h82, 1, 0, 2, 1, 0, 8'h82);
        step(3'd4, 0, 8'h00, 8'h00, 0, 0, -1, 1, 8'h81, 1, 0, 1, 1, 0, 8'h81);
        step(3'd4, 0, 8'h00, 8'h00, 0, 0, -1, 1, 8'h07, 1, 0, 0, 1, 0, 8'h07);
        step(3'd4, 0, 8'h00, 8'h00, 0, 0, -1, 0, 8'h00, 0, 1, 0, 1, 1, 8'h07);
        step(3'd0, 0, 8'h00, 8'h00, 1, 0, -1, 1, 8'h07, 0, 0, 0, 1, 1, 8'h07);
        // HALT op, frozen despite JUMP, resume
        step(3'd5, 0, 8'h00, 8'h00, 0, 0, -1, 0, 8'h00, 0, 1, 0, 1, 1, 8'h07);
        step(3'd2, 0, 8'h00, 8'h33, 0, 0, -1, 1, 8'h07, 0, 1, 0, 1, 1, 8'h07);
        step(3'd2, 0, 8'h00, 8'h33, 0, 0, -1, 1, 8'h07, 0, 1, 0, 1, 1, 8'h07);
        step(3'd2, 0, 8'h00, 8'h33, 0, 0, -1, 1, 8'h07, 0, 1, 0, 1, 1, 8'h07);
        step(3'd2, 0, 8'h00, 8'h33, 1, 0, -1, 1, 8'h07, 0, 0, 0, 1, 1, 8'h07);
        step(3'd0, 0, 8'h00, 8'h00, 0, 0, -1, 1, 8'h08, 1, 0, 0, 1, 1, 8'h08);
        step(3'd7, 0, 8'h00, 8'h00, 1, 0, -1, 1, 8'h09, 1, 0, 0, 1, 1, 8'h09);
        // reset mid-operation
        step(3'd3, 0, 8'h00, 8'h50, 0, 0, -1, 1, 8'h50, 1, 0, 1, 1, 1, 8'h50);
        step(3'd3, 0, 8'h00, 8'h70, 0, 0, -1, 1, 8'h70, 1, 0, 2, 1, 1, 8'h70);
        step(3'd3, 0, 8'h00, 8'h99, 1, 1, -1, 1, 8'h00, 1, 0, 0, 0, 0, 8'h00);
        step(3'd0, 0, 8'h00, 8'h00, 0, 0, -1, 1, 8'h01, 1, 0, 0, 0, 0, 8'h01);
        stimDone = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!(stimDone && sb.size() == 0) && budget < 1000) begin
            @(negedge clock);
            budget++;
        end
        if (budget >= 1000) begin
            nCmp++;
            nBad++;
            $display("FAIL timeout: queue=%0d left, expected 0", sb.size());
        end
        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
